piso_unloader: RTL
==================

Name: piso_unloader

Overview:
- Parallel-in, serial-out unloader.
- Captures a WIDTH-bit word in a single load cycle, then emits it one bit at a time over a valid/ready handshake, and pulses done when the last bit is accepted.
- It is the read-out side for the codebase's D-type registers: a register's q output feeds din, and this block streams the value to a serial consumer.

Parameters:
- WIDTH, 8, word width in bits; legal range is 1 and up.
- MSB_FIRST, 1, bit order: 1 emits bit WIDTH-1 first, 0 emits bit 0 first.

Ports:
- clk  input  1  clock; all state updates occur on the falling edge (negedge), as everywhere in the codebase.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  load request; sampled only in IDLE.
- din  input  WIDTH  parallel word, captured when start is accepted.
- busy  output  1  high in SHIFT and DONE.
- bit_out  output  1  current serial bit; 0 whenever bit_valid is 0.
- bit_valid  output  1  bit_out holds a bit offered to the consumer.
- bit_ready  input  1  consumer accepts bit_out at this edge.
- done  output  1  one-cycle pulse after the final bit is accepted.

Behaviour:
- Reset, rst=1 at any time, including mid-word:
  - state goes to IDLE immediately, without waiting for a clock edge;
  - shift register and bit counter are cleared to 0;
  - busy=0, bit_valid=0, bit_out=0, done=0;
  - any partially sent word is discarded.
- State register: IDLE, SHIFT, DONE. Bit counter width is clog2(WIDTH+1).
- IDLE:
  - busy=0, bit_valid=0.
  - On a falling edge with start=1: sreg<=din, cnt<=0, go to SHIFT.
  - din is sampled only at that edge; later changes to din have no effect.
- SHIFT:
  - busy=1, bit_valid=1.
  - bit_out = sreg[WIDTH-1] if MSB_FIRST, else sreg[0].
  - Transfer occurs at a falling edge with bit_valid=1 and bit_ready=1. On each transfer:
    - sreg shifts toward the output end (left if MSB_FIRST, right otherwise);
    - a 0 fills the vacated bit;
    - cnt increments.
  - With bit_ready=0: sreg, cnt and bit_out hold. Stalls may last any number of cycles.
  - The transfer that brings cnt to WIDTH moves the state to DONE.
  - Back-to-back transfers (bit_ready held at 1) emit one bit per cycle, so a full word takes WIDTH cycles in SHIFT.
- DONE:
  - Lasts exactly one cycle: busy=1, bit_valid=0, done=1.
  - The next edge returns to IDLE unconditionally.
- Latency:
  - bit_valid rises in the cycle after the start edge.
  - With no stalls, done is high WIDTH cycles after that.
  - The earliest next start is accepted at the edge that ends the first IDLE cycle after DONE, giving a minimum word period of WIDTH+2 cycles.
- Start while busy (SHIFT or DONE): ignored. It is not queued, and the word in flight is unaffected.
- bit_ready while not in SHIFT: ignored.
- WIDTH=1: SHIFT lasts until the single transfer, then DONE; no special case is needed.
- Counter never wraps: transitions are decided by cnt reaching WIDTH, and cnt is cleared on every load.
- Outputs are registered or decoded from registered state only. There is no combinational path from bit_ready or start to any output.

Test Plan:
- Reset: assert rst mid-clock with no clock edge. Outputs go to 0 immediately. Hold rst=1 over 3 edges with start=1: block stays in IDLE.
- MSB-first stream: WIDTH=8, MSB_FIRST=1, din=8'hA5, start pulse, bit_ready=1 throughout.
  - Bits are 1,0,1,0,0,1,0,1 on 8 consecutive edges.
  - done=1 for exactly one cycle; busy drops after it.
- Backpressure: same word with MSB_FIRST=0. Deassert bit_ready for 3 cycles after the 2nd bit and for 1 cycle before the last bit.
  - Sequence is 1,0,1,0,0,1,0,1 with no duplicated or lost bits.
  - bit_out and bit_valid hold during the stalls.
- Start while busy: pulse start with din=8'hFF during SHIFT of 8'h3C. Output is still 8'h3C's bits, and exactly one done pulse occurs.
- Reset mid-word: assert rst after 4 of 8 bits. bit_valid=0 immediately. After release, a new start with din=8'h81 streams 1,0,0,0,0,0,0,1 correctly.
- Back-to-back words: start held at 1 continuously with 8'h01 then 8'h80.
  - Two words are emitted.
  - Exactly one IDLE cycle separates them; the period is 10 cycles.

Source files
------------

// File: rtl/piso_unloader_if.sv
// Handshake bundle between a parallel-in/serial-out unloader and its host/consumer.
// The unloader side uses the master modport; the host/consumer side uses slave.
interface piso_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_ready;
  logic             done;

  modport master (
    input  start,
    input  din,
    input  bit_ready,
    output busy,
    output bit_out,
    output bit_valid,
    output done
  );

  modport slave (
    output start,
    output din,
    output bit_ready,
    input  busy,
    input  bit_out,
    input  bit_valid,
    input  done
  );
endinterface

// File: rtl/piso_unloader.sv
// Parallel-in, serial-out unloader: loads a word on start, streams it bit by bit over
// valid/ready on the falling clock edge, then pulses done for one cycle.
module piso_unloader #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic   clk,
  input logic   rst,
  piso_if.master bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_shift;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             valid_q;
  logic             bit_q;
  logic             done_q;

  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  always_comb begin
    sreg_shift = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
  end

  // All outputs are flops updated together with the state, so no input reaches an
  // output combinationally; bit_q is preloaded with the bit the next state will offer.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      bit_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StShift;
            sreg_q  <= bus.din;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            bit_q   <= out_bit(bus.din);
          end
        end
        StShift: begin
          if (bus.bit_ready) begin
            sreg_q <= sreg_shift;
            cnt_q  <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              state_q <= StDone;
              valid_q <= 1'b0;
              bit_q   <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              bit_q <= out_bit(sreg_shift);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          bit_q   <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.bit_valid = valid_q;
  assign bus.bit_out   = bit_q;
  assign bus.done      = done_q;

endmodule
